// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: run control inputs and frame timing outputs.
// master = timing generator, slave = consumer. pix_data exists only with VTG_TEST_PATTERN_EN.
interface video_timing_gen_if;
  logic        run;
  logic        oneshot;
  logic        frame_vsync;
  logic        frame_href;
  logic        frame_clken;
  logic [10:0] x_pos;
  logic [10:0] y_pos;
  logic        frame_start;
  logic        frame_end;
  logic [15:0] frame_cnt;
  logic        busy;
`ifdef VTG_TEST_PATTERN_EN
  logic [23:0] pix_data;
`endif

  modport master (
    input  run,
    input  oneshot,
    output frame_vsync,
    output frame_href,
    output frame_clken,
    output x_pos,
    output y_pos,
    output frame_start,
    output frame_end,
    output frame_cnt,
    output busy
`ifdef VTG_TEST_PATTERN_EN
    , output pix_data
`endif
  );

  modport slave (
    output run,
    output oneshot,
    input  frame_vsync,
    input  frame_href,
    input  frame_clken,
    input  x_pos,
    input  y_pos,
    input  frame_start,
    input  frame_end,
    input  frame_cnt,
    input  busy
`ifdef VTG_TEST_PATTERN_EN
    , input pix_data
`endif
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: prescaled h/v counters, IDLE/RUN/DRAIN control, registered sync/href/pos/pulses.
// Ports: sys_clk, sys_rst_n (async, active-low), vif (master). Macro VTG_TEST_PATTERN_EN adds colour-bar pix_data.
module video_timing_gen #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_SYNC    = 5,
  parameter int H_BACK    = 5,
  parameter int H_FRONT   = 5,
  parameter int V_SYNC    = 1,
  parameter int V_BACK    = 0,
  parameter int V_FRONT   = 1,
  parameter bit VSYNC_ACT = 1'b0,
  parameter int CLKEN_DIV = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  video_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_SYNC + H_BACK + IMG_HDISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + IMG_VDISP + V_FRONT;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_A0   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_A1   = 11'(H_SYNC + H_BACK + IMG_HDISP);
  localparam logic [10:0] V_A0   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_A1   = 11'(V_SYNC + V_BACK + IMG_VDISP);
  localparam logic [10:0] V_SY   = 11'(V_SYNC);
  localparam logic [3:0]  P_LAST = 4'(CLKEN_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e      state_q, state_d;
  logic        osl_q, osl_d;
  logic [3:0]  presc_q, presc_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;

  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic        clken_q, clken_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        start_q, start_d;
  logic        end_q, end_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;

  logic tick, h_wrap, f_wrap, active;

  always_comb begin
    tick   = (presc_q == P_LAST);
    h_wrap = tick && (hcnt_q == H_LAST);
    f_wrap = h_wrap && (vcnt_q == V_LAST);
    active = (state_q != IDLE);

    state_d = state_q;
    osl_d   = osl_q;
    presc_d = '0;
    hcnt_d  = '0;
    vcnt_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (vif.run) begin
          state_d = RUN;
          osl_d   = vif.oneshot;
        end
      end
      RUN: begin
        if (f_wrap) begin
          // oneshot is re-sampled at every new frame start
          if (vif.run && !osl_q) osl_d = vif.oneshot;
          else state_d = IDLE;
        end else if (!vif.run || osl_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (f_wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (active) begin
      presc_d = tick ? 4'd0 : presc_q + 4'd1;
      hcnt_d  = hcnt_q;
      vcnt_d  = vcnt_q;
      if (tick) begin
        hcnt_d = h_wrap ? 11'd0 : hcnt_q + 11'd1;
        if (h_wrap)
          vcnt_d = (vcnt_q == V_LAST) ? 11'd0 : vcnt_q + 11'd1;
      end
    end

    vsync_d = (active && vcnt_q < V_SY) ? VSYNC_ACT : ~VSYNC_ACT;
    href_d  = active
           && vcnt_q >= V_A0 && vcnt_q < V_A1
           && hcnt_q >= H_A0 && hcnt_q < H_A1;
    clken_d = href_d && tick;
    x_d     = href_d ? hcnt_q - H_A0 : 11'd0;
    y_d     = href_d ? vcnt_q - V_A0 : 11'd0;
    start_d = active && presc_q == 4'd0
           && hcnt_q == 11'd0 && vcnt_q == 11'd0;
    end_d   = active && f_wrap;
    cnt_d   = cnt_q + 16'(end_d);
    busy_d  = active;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      osl_q   <= 1'b0;
      presc_q <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      vsync_q <= ~VSYNC_ACT;
      href_q  <= 1'b0;
      clken_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      osl_q   <= osl_d;
      presc_q <= presc_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      clken_q <= clken_d;
      x_q     <= x_d;
      y_q     <= y_d;
      start_q <= start_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign vif.frame_vsync = vsync_q;
  assign vif.frame_href  = href_q;
  assign vif.frame_clken = clken_q;
  assign vif.x_pos       = x_q;
  assign vif.y_pos       = y_q;
  assign vif.frame_start = start_q;
  assign vif.frame_end   = end_q;
  assign vif.frame_cnt   = cnt_q;
  assign vif.busy        = busy_q;

`ifdef VTG_TEST_PATTERN_EN
  logic [2:0]  bar;
  logic [23:0] pix_q, pix_d;

  // bar bits map directly to channel enables:
  // R off when bar[1], G off when bar[2], B off when bar[0]
  always_comb begin
    bar   = 3'({x_d, 3'b000} / 14'(IMG_HDISP));
    pix_d = href_d ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}}
                   : 24'd0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pix_q <= '0;
    else            pix_q <= pix_d;
  end

  assign vif.pix_data = pix_q;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: two generators (CLKEN_DIV 1 and 3) vs a frame-position model.
// Directed run/oneshot/reset phases followed by random run/oneshot traffic.
module tb_video_timing_gen;
  localparam int HD = 4, VD = 2;
  localparam int HS = 1, HB = 1, HF = 1;
  localparam int VS = 1, VB = 0, VF = 1;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam bit ACT = 1'b0;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  video_timing_gen_if vif0 ();
  video_timing_gen_if vif1 ();

  video_timing_gen #(
    .IMG_HDISP(HD), .IMG_VDISP(VD),
    .H_SYNC(HS), .H_BACK(HB), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF),
    .VSYNC_ACT(ACT), .CLKEN_DIV(1)
  ) dut0 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .vif(vif0.master));

  video_timing_gen #(
    .IMG_HDISP(HD), .IMG_VDISP(VD),
    .H_SYNC(HS), .H_BACK(HB), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF),
    .VSYNC_ACT(ACT), .CLKEN_DIV(3)
  ) dut1 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .vif(vif1.master));

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int DIVS [2] = '{1, 3};
  bit m_act [2], m_stop [2], m_drain [2];
  int m_pos [2], m_cnt [2];

  logic e_vs [2], e_hr [2], e_ck [2], e_st [2], e_en [2], e_bs [2];
  int   e_x [2], e_y [2], e_cnt [2];
  logic [23:0] e_pix [2];
  logic [23:0] colours [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
    24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_stop[k] = 0; m_drain[k] = 0;
      m_pos[k] = 0; m_cnt[k] = 0;
      e_vs[k] = ~ACT; e_hr[k] = 0; e_ck[k] = 0; e_st[k] = 0;
      e_en[k] = 0; e_bs[k] = 0; e_x[k] = 0; e_y[k] = 0;
      e_cnt[k] = 0; e_pix[k] = 0;
    end
  endtask

  // Expected registered outputs for the cycle ending at the next edge,
  // then advance the frame position by one sys_clk cycle.
  task automatic predict(input int k, input logic r, input logic o);
    int p, h, v, flen;
    flen = HT * VT * DIVS[k];
    e_vs[k] = ~ACT; e_hr[k] = 0; e_ck[k] = 0; e_st[k] = 0;
    e_en[k] = 0; e_x[k] = 0; e_y[k] = 0; e_pix[k] = 0;
    e_bs[k] = m_act[k];
    if (m_act[k]) begin
      p = m_pos[k] / DIVS[k];
      h = p % HT;
      v = p / HT;
      e_vs[k] = (v < VS) ? ACT : ~ACT;
      e_hr[k] = (v >= VS + VB) && (v < VS + VB + VD)
             && (h >= HS + HB) && (h < HS + HB + HD);
      e_ck[k] = e_hr[k] && (m_pos[k] % DIVS[k] == DIVS[k] - 1);
      if (e_hr[k]) begin
        e_x[k] = h - HS - HB;
        e_y[k] = v - VS - VB;
        e_pix[k] = colours[(e_x[k] * 8) / HD];
      end
      e_st[k] = (m_pos[k] == 0);
      e_en[k] = (m_pos[k] == flen - 1);
      if (e_en[k]) m_cnt[k] = (m_cnt[k] + 1) % 65536;
    end
    e_cnt[k] = m_cnt[k];
    if (!m_act[k]) begin
      if (r) begin
        m_act[k] = 1; m_pos[k] = 0;
        m_stop[k] = o; m_drain[k] = 0;
      end
    end else if (m_pos[k] == flen - 1) begin
      if (r && !m_stop[k] && !m_drain[k]) begin
        m_pos[k] = 0; m_stop[k] = o;
      end else begin
        m_act[k] = 0; m_drain[k] = 0;
      end
    end else begin
      m_pos[k]++;
      if (!r || m_stop[k]) m_drain[k] = 1;
    end
  endtask

  task automatic cmp(input int k, input logic vs, input logic hr,
                     input logic ck, input logic [10:0] x,
                     input logic [10:0] y, input logic st,
                     input logic en, input logic [15:0] cnt,
                     input logic bs);
    chk($sformatf("vsync[%0d]", k), 32'(vs), 32'(e_vs[k]));
    chk($sformatf("href[%0d]", k), 32'(hr), 32'(e_hr[k]));
    chk($sformatf("clken[%0d]", k), 32'(ck), 32'(e_ck[k]));
    chk($sformatf("x_pos[%0d]", k), 32'(x), e_x[k]);
    chk($sformatf("y_pos[%0d]", k), 32'(y), e_y[k]);
    chk($sformatf("start[%0d]", k), 32'(st), 32'(e_st[k]));
    chk($sformatf("end[%0d]", k), 32'(en), 32'(e_en[k]));
    chk($sformatf("frame_cnt[%0d]", k), 32'(cnt), e_cnt[k]);
    chk($sformatf("busy[%0d]", k), 32'(bs), 32'(e_bs[k]));
  endtask

  task automatic cmp_all();
    cmp(0, vif0.frame_vsync, vif0.frame_href, vif0.frame_clken,
        vif0.x_pos, vif0.y_pos, vif0.frame_start, vif0.frame_end,
        vif0.frame_cnt, vif0.busy);
    cmp(1, vif1.frame_vsync, vif1.frame_href, vif1.frame_clken,
        vif1.x_pos, vif1.y_pos, vif1.frame_start, vif1.frame_end,
        vif1.frame_cnt, vif1.busy);
`ifdef VTG_TEST_PATTERN_EN
    chk("pix[0]", 32'(vif0.pix_data), 32'(e_pix[0]));
    chk("pix[1]", 32'(vif1.pix_data), 32'(e_pix[1]));
`endif
  endtask

  task automatic step(input logic r, input logic o);
    vif0.run = r; vif0.oneshot = o;
    vif1.run = r; vif1.oneshot = o;
    predict(0, r, o);
    predict(1, r, o);
    @(posedge sys_clk);
    #1;
    cmp_all();
  endtask

  task automatic do_reset(input int hold);
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    for (int i = 0; i < hold; i++) begin
      @(posedge sys_clk);
      #1;
      cmp_all();
    end
    sys_rst_n = 1'b1;
  endtask

  initial begin
    logic r, o;
    vif0.run = 0; vif0.oneshot = 0;
    vif1.run = 0; vif1.oneshot = 0;
    sys_rst_n = 1'b1;
    #2;
    do_reset(2);

    for (int i = 0; i < 180; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0);

    step(1'b1, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0);

    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 70; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0);

    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    do_reset(1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);

    r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) r = ~r;
      o = ($urandom_range(0, 7) == 0);
      step(r, o);
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    do_reset(1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter IMG_HDISP, default 640: active pixels per line.
REQ-002 Parameter IMG_VDISP, default 480: active lines per frame.
REQ-003 Parameters H_SYNC/H_BACK/H_FRONT, defaults 5/5/5: horizontal sync, back porch and front porch, in pixels.
REQ-004 Parameters V_SYNC/V_BACK/V_FRONT, defaults 1/0/1: vertical sync, back porch and front porch, in lines.
REQ-005 Parameter VSYNC_ACT, default 0: level driven on frame_vsync during the sync interval; the opposite level elsewhere.
REQ-006 Parameter CLKEN_DIV, default 1, range 1..16: sys_clk cycles per pixel period.
REQ-007 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-008 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 run  in  1  level; high starts or continues frame generation.
REQ-010 oneshot  in  1  sampled at frame start; 1 = stop after the current frame.
REQ-011 frame_vsync  out  1  vertical sync.
REQ-012 frame_href  out  1  high during active pixel periods.
REQ-013 frame_clken  out  1  one-cycle pixel strobe, high only when frame_href is high.
REQ-014 x_pos / y_pos  out  11 each  active pixel coordinates; 0 outside the active region.
REQ-015 frame_start / frame_end  out  1 each  one-cycle pulses.
REQ-016 frame_cnt  out  16  number of completed frames; wraps at 65535 -> 0.
REQ-017 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-018 H_TOTAL = H_SYNC+H_BACK+IMG_HDISP+H_FRONT. V_TOTAL = V_SYNC+V_BACK+IMG_VDISP+V_FRONT. Both are computed at elaboration time and must fit in 11 bits.
REQ-019 Prescaler counts 0..CLKEN_DIV-1. Pixel tick = prescaler at terminal count; with CLKEN_DIV=1 the tick is asserted every cycle.
REQ-020 hcnt counts 0..H_TOTAL-1 and advances on each pixel tick. vcnt advances when hcnt wraps and itself wraps at V_TOTAL-1.
REQ-021 FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when run=1; counters start at 0, 0.
  - RUN -> DRAIN when run=0 mid-frame, or when oneshot was latched.
  - DRAIN -> IDLE at the frame wrap.
  - RUN at the frame wrap with run=1 and oneshot latch=0: stays in RUN.
REQ-022 Counters and the prescaler are held at 0 in IDLE. run=0 in DRAIN never truncates a frame; run=1 in DRAIN does not cancel the drain.
REQ-023 All outputs are registered and derived from the counter values of the previous cycle, so they show 1-cycle latency relative to hcnt/vcnt.
REQ-024 frame_vsync = VSYNC_ACT while vcnt < V_SYNC, otherwise ~VSYNC_ACT. In IDLE it is ~VSYNC_ACT.
REQ-025 frame_href = 1 while vcnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+IMG_VDISP) and hcnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+IMG_HDISP).
REQ-026 frame_clken = frame_href AND the registered pixel tick; it pulses once per pixel even when CLKEN_DIV>1.
REQ-027 x_pos = hcnt-(H_SYNC+H_BACK) and y_pos = vcnt-(V_SYNC+V_BACK) while in the active region.
REQ-028 frame_start pulses on the first pixel period of each frame, at hcnt=0 and vcnt=0.
REQ-029 frame_end pulses on the last pixel tick of each frame, and frame_cnt increments in that same cycle.

Reset
REQ-030 Reset puts the FSM in IDLE and clears all counters, frame_cnt and pulses. frame_vsync resets to ~VSYNC_ACT; all other outputs reset to 0.
REQ-031 Reset mid-frame aborts the frame immediately and produces no frame_end pulse.

Configuration
REQ-032 With macro VTG_TEST_PATTERN_EN defined, the block adds output pix_data[23:0], registered and aligned with frame_href.
  - The pattern is 8 vertical colour bars, bar index = x_pos*8/IMG_HDISP: white, yellow, cyan, green, magenta, red, blue, black, in RGB888.
  - pix_data is 0 outside the active region.
REQ-033 Without the macro, the port and its logic are absent, and timing behaviour is identical.

Verification
Params for REQ-034..REQ-037: IMG_HDISP=4, IMG_VDISP=2, H_SYNC/H_BACK/H_FRONT=1/1/1, V_SYNC/V_BACK/V_FRONT=1/0/1, CLKEN_DIV=1.
REQ-034 run=1, oneshot=0 for 56 cycles -> frame_start every 28 cycles; href high 4 cycles per active line with x_pos 0,1,2,3; frame_cnt=2.
REQ-035 oneshot=1, run=1 -> exactly one frame of 28 cycles, one frame_end, frame_cnt=1, busy falls one cycle after frame_end.
REQ-036 run dropped at cycle 10 -> frame completes to cycle 27, FSM returns to IDLE, no further href.
REQ-037 sys_rst_n asserted at cycle 12 -> all outputs return to reset values the same cycle; frame_cnt=0; no frame_end.
REQ-038 CLKEN_DIV=3 -> frame lasts 84 cycles; frame_clken pulses once every 3 cycles within href, 8 pulses per frame.
REQ-039 VTG_TEST_PATTERN_EN defined, IMG_HDISP=8 -> pix_data sequence FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 per line.
